// File: rtl/change_dispenser.sv
// change_dispenser
//   Coin-change dispense controller. Keeps the inventory of the 25/50/100
//   coin tubes, turns a requested change value into a greedy per-denomination
//   coin plan and drives the ejector solenoids one coin at a time, waiting for
//   the drop sensor after each pulse.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   req, amount[7:0]        - dispense request and change value in cents (IDLE only)
//   load_25/50/100          - one coin added to the matching tube this cycle
//   coin_sensed             - single-cycle pulse from the drop sensor
//   eject_25/50/100         - solenoid drives, at most one high at a time
//   busy, done, fail, jam   - status (done/fail are one-cycle pulses, jam is sticky)
//   count_25/50/100[3:0]    - tube inventory, saturating at TUBE_MAX
//   dispensed[7:0]          - value ejected in the current or last request
module change_dispenser #(
  parameter int PULSE_CYCLES   = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TUBE_MAX       = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] amount,
  input  logic       load_25,
  input  logic       load_50,
  input  logic       load_100,
  input  logic       coin_sensed,
  output logic       eject_25,
  output logic       eject_50,
  output logic       eject_100,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic       jam,
  output logic [3:0] count_25,
  output logic [3:0] count_50,
  output logic [3:0] count_100,
  output logic [7:0] dispensed
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLAN  = 3'd1,
    ST_EJECT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAIL  = 3'd6,
    ST_JAM   = 3'd7
  } state_t;

  state_t      state;
  logic [7:0]  amount_q;
  logic [3:0]  n100, n50, n25;      // coins still to eject per denomination
  logic [2:0]  eject_vec;           // {100, 50, 25}
  logic [15:0] timer;
  logic        sense_pending;       // sense seen while the pulse was still active

  logic [7:0]  q100, q50, q25, r1, r2, r3;
  logic [3:0]  p100, p50, p25;
  logic [2:0]  cur;
  logic [7:0]  coin_value;
  logic [5:0]  coins_left;
  logic        more_left;
  logic        sense_hit;

  // Highest denomination that still has coins to go, as a one-hot {100,50,25}.
  function automatic logic [2:0] pick_coin(input logic [3:0] a100,
                                           input logic [3:0] a50,
                                           input logic [3:0] a25);
    logic [2:0] sel;
    if (a100 != 4'd0)     sel = 3'b100;
    else if (a50 != 4'd0) sel = 3'b010;
    else if (a25 != 4'd0) sel = 3'b001;
    else                  sel = 3'b000;
    return sel;
  endfunction

  // Tube count update: a load and a removal in the same cycle cancel out.
  function automatic logic [3:0] next_count(input logic [3:0] c,
                                            input logic       inc,
                                            input logic       dec);
    logic [3:0] n;
    if (inc && !dec) begin
      if (c < 4'(TUBE_MAX)) n = c + 4'd1;
      else                  n = c;
    end else if (dec && !inc) begin
      if (c != 4'd0) n = c - 4'd1;
      else           n = c;
    end else begin
      n = c;
    end
    return n;
  endfunction

  // Greedy plan limited by what each tube actually holds; r3 is the residue.
  always_comb begin
    q100 = amount_q / 8'd100;
    if (q100 > {4'd0, count_100}) p100 = count_100;
    else                          p100 = q100[3:0];
    r1 = amount_q - (8'd100 * {4'd0, p100});
    q50 = r1 / 8'd50;
    if (q50 > {4'd0, count_50}) p50 = count_50;
    else                        p50 = q50[3:0];
    r2 = r1 - (8'd50 * {4'd0, p50});
    q25 = r2 / 8'd25;
    if (q25 > {4'd0, count_25}) p25 = count_25;
    else                        p25 = q25[3:0];
    r3 = r2 - (8'd25 * {4'd0, p25});
  end

  // Active coin, its value and whether more coins follow it.
  always_comb begin
    cur = pick_coin(n100, n50, n25);
    if (cur[2])      coin_value = 8'd100;
    else if (cur[1]) coin_value = 8'd50;
    else             coin_value = 8'd25;
    coins_left = {2'b00, n100} + {2'b00, n50} + {2'b00, n25};
    more_left  = (coins_left > 6'd1);
    sense_hit  = (state == ST_WAIT) && (coin_sensed || sense_pending);
  end

  assign eject_100 = eject_vec[2];
  assign eject_50  = eject_vec[1];
  assign eject_25  = eject_vec[0];

  // Dispense sequencer, registered outputs and tube inventory.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      amount_q      <= 8'd0;
      n100          <= 4'd0;
      n50           <= 4'd0;
      n25           <= 4'd0;
      eject_vec     <= 3'b000;
      timer         <= 16'd0;
      sense_pending <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
      jam           <= 1'b0;
      count_25      <= 4'd0;
      count_50      <= 4'd0;
      count_100     <= 4'd0;
      dispensed     <= 8'd0;
    end else begin
      count_100 <= next_count(count_100, load_100, sense_hit && cur[2]);
      count_50  <= next_count(count_50,  load_50,  sense_hit && cur[1]);
      count_25  <= next_count(count_25,  load_25,  sense_hit && cur[0]);

      case (state)
        ST_IDLE: begin
          if (req) begin
            amount_q  <= amount;
            dispensed <= 8'd0;
            busy      <= 1'b1;
            state     <= ST_PLAN;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_PLAN: begin
          n100 <= p100;
          n50  <= p50;
          n25  <= p25;
          if (r3 != 8'd0) begin
            fail  <= 1'b1;
            state <= ST_FAIL;
          end else if ((p100 == 4'd0) && (p50 == 4'd0) && (p25 == 4'd0)) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            eject_vec     <= pick_coin(p100, p50, p25);
            timer         <= 16'd0;
            sense_pending <= 1'b0;
            state         <= ST_EJECT;
          end
        end
        ST_EJECT: begin
          if (coin_sensed) begin
            sense_pending <= 1'b1;
          end
          if (timer == 16'(PULSE_CYCLES - 1)) begin
            eject_vec <= 3'b000;
            timer     <= 16'd0;
            state     <= ST_WAIT;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_WAIT: begin
          if (sense_hit) begin
            sense_pending <= 1'b0;
            dispensed     <= dispensed + coin_value;
            timer         <= 16'd0;
            if (cur[2])      n100 <= n100 - 4'd1;
            else if (cur[1]) n50  <= n50 - 4'd1;
            else             n25  <= n25 - 4'd1;
            if (more_left) begin
              state <= ST_GAP;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end else if (timer == 16'(TIMEOUT_CYCLES - 1)) begin
            jam   <= 1'b1;
            state <= ST_JAM;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_GAP: begin
          // n registers already reflect the coin just sensed.
          if (timer == 16'(GAP_CYCLES - 1)) begin
            eject_vec     <= cur;
            timer         <= 16'd0;
            sense_pending <= 1'b0;
            state         <= ST_EJECT;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_FAIL: begin
          fail  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_JAM: begin
          jam       <= 1'b1;
          busy      <= 1'b1;
          eject_vec <= 3'b000;
        end
        default: begin
          eject_vec <= 3'b000;
          busy      <= 1'b0;
          done      <= 1'b0;
          fail      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  localparam int P = 4;
  localparam int G = 2;
  localparam int T = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic [7:0] amount = 8'd0;
  logic       load_25 = 1'b0, load_50 = 1'b0, load_100 = 1'b0;
  logic       coin_sensed = 1'b0;
  logic       eject_25, eject_50, eject_100;
  logic       busy, done, fail, jam;
  logic [3:0] count_25, count_50, count_100;
  logic [7:0] dispensed;

  int checks = 0;
  int failures = 0;
  int m25 = 0, m50 = 0, m100 = 0;   // reference tube inventory

  change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .TUBE_MAX(15)) dut (
    .clock(clock), .reset(reset), .req(req), .amount(amount),
    .load_25(load_25), .load_50(load_50), .load_100(load_100),
    .coin_sensed(coin_sensed),
    .eject_25(eject_25), .eject_50(eject_50), .eject_100(eject_100),
    .busy(busy), .done(done), .fail(fail), .jam(jam),
    .count_25(count_25), .count_50(count_50), .count_100(count_100),
    .dispensed(dispensed)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] ej_of(input int v);
    logic [2:0] e;
    e = (v == 100) ? 3'b100 : (v == 50) ? 3'b010 : (v == 25) ? 3'b001 : 3'b000;
    return e;
  endfunction

  function automatic logic [11:0] model_counts();
    logic [11:0] c;
    c = {4'(m100), 4'(m50), 4'(m25)};
    return c;
  endfunction

  task automatic load_mix(input bit b100, input bit b50, input bit b25);
    load_100 = b100; load_50 = b50; load_25 = b25;
    tick;
    load_100 = 1'b0; load_50 = 1'b0; load_25 = 1'b0;
    if (b100 && m100 < 15) m100++;
    if (b50 && m50 < 15) m50++;
    if (b25 && m25 < 15) m25++;
  endtask

  task automatic load_coins(input int a100, input int a50, input int a25);
    for (int i = 0; i < a100; i++) load_mix(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < a50; i++) load_mix(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < a25; i++) load_mix(1'b0, 1'b0, 1'b1);
  endtask

  // Full request: the reference plan is built coin by coin from the inventory.
  task automatic do_dispense(input int amt, input bit load_on_sense);
    int coins[$];
    int rem, a100, a50, a25, exp_disp;
    rem = amt; a100 = m100; a50 = m50; a25 = m25; exp_disp = 0;
    while (rem >= 100 && a100 > 0) begin coins.push_back(100); rem -= 100; a100--; end
    while (rem >= 50 && a50 > 0) begin coins.push_back(50); rem -= 50; a50--; end
    while (rem >= 25 && a25 > 0) begin coins.push_back(25); rem -= 25; a25--; end

    req = 1'b1; amount = 8'(amt);
    tick;
    req = 1'b0;
    checks++;
    if (busy !== 1'b1 || {eject_100, eject_50, eject_25} !== 3'b000) begin
      failures++; $display("FAIL plan_cycle amt=%0d: busy=%b ej=%b required busy=1 ej=000", amt, busy, {eject_100, eject_50, eject_25});
    end

    if (rem != 0) begin
      tick;
      checks++;
      if (fail !== 1'b1 || done !== 1'b0 || {eject_100, eject_50, eject_25} !== 3'b000) begin
        failures++; $display("FAIL fail_pulse amt=%0d: fail=%b done=%b ej=%b required 1 0 000", amt, fail, done, {eject_100, eject_50, eject_25});
      end
      tick;
      checks++;
      if (busy !== 1'b0 || fail !== 1'b0 || dispensed !== 8'd0 || {count_100, count_50, count_25} !== model_counts()) begin
        failures++; $display("FAIL fail_after amt=%0d: busy=%b fail=%b disp=%0d counts=%h required 0 0 0 %h", amt, busy, fail, dispensed, {count_100, count_50, count_25}, model_counts());
      end
    end else if (coins.size() == 0) begin
      tick;
      checks++;
      if (done !== 1'b1 || fail !== 1'b0 || {eject_100, eject_50, eject_25} !== 3'b000) begin
        failures++; $display("FAIL zero_done amt=%0d: done=%b fail=%b ej=%b required 1 0 000", amt, done, fail, {eject_100, eject_50, eject_25});
      end
      tick;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++; $display("FAIL zero_after: busy=%b done=%b required 0 0", busy, done);
      end
    end else begin
      for (int i = 0; i < coins.size(); i++) begin
        tick;
        for (int p = 0; p < P; p++) begin
          checks++;
          if ({eject_100, eject_50, eject_25} !== ej_of(coins[i]) || done !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL eject coin%0d cyc%0d: ej=%b done=%b busy=%b required ej=%b 0 1", i, p, {eject_100, eject_50, eject_25}, done, busy, ej_of(coins[i]));
          end
          if (p < P - 1) tick;
        end
        tick;
        checks++;
        if ({eject_100, eject_50, eject_25} !== 3'b000 || busy !== 1'b1) begin
          failures++; $display("FAIL wait_cycle coin%0d: ej=%b busy=%b required 000 1", i, {eject_100, eject_50, eject_25}, busy);
        end
        coin_sensed = 1'b1;
        if (load_on_sense) begin
          load_100 = (coins[i] == 100); load_50 = (coins[i] == 50); load_25 = (coins[i] == 25);
        end
        tick;
        coin_sensed = 1'b0; load_100 = 1'b0; load_50 = 1'b0; load_25 = 1'b0;
        exp_disp += coins[i];
        if (!load_on_sense) begin
          if (coins[i] == 100) m100--;
          else if (coins[i] == 50) m50--;
          else m25--;
        end
        checks++;
        if (dispensed !== 8'(exp_disp) || {count_100, count_50, count_25} !== model_counts()) begin
          failures++; $display("FAIL sensed coin%0d: disp=%0d counts=%h required %0d %h", i, dispensed, {count_100, count_50, count_25}, exp_disp, model_counts());
        end
        if (i == coins.size() - 1) begin
          checks++;
          if (done !== 1'b1 || {eject_100, eject_50, eject_25} !== 3'b000) begin
            failures++; $display("FAIL done_pulse amt=%0d: done=%b ej=%b required 1 000", amt, done, {eject_100, eject_50, eject_25});
          end
          tick;
          checks++;
          if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL done_after amt=%0d: busy=%b done=%b required 0 0", amt, busy, done);
          end
        end else begin
          for (int g = 0; g < G; g++) begin
            checks++;
            if ({eject_100, eject_50, eject_25} !== 3'b000 || done !== 1'b0) begin
              failures++; $display("FAIL gap coin%0d cyc%0d: ej=%b done=%b required 000 0", i, g, {eject_100, eject_50, eject_25}, done);
            end
            if (g < G - 1) tick;
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    m25 = 0; m50 = 0; m100 = 0;
    checks++;
    if ({eject_100, eject_50, eject_25, busy, done, fail, jam} !== 7'd0 ||
        {count_100, count_50, count_25} !== 12'd0 || dispensed !== 8'd0) begin
      failures++; $display("FAIL reset_values: ej=%b bdfj=%b counts=%h disp=%0d required all zero",
        {eject_100, eject_50, eject_25}, {busy, done, fail, jam}, {count_100, count_50, count_25}, dispensed);
    end
  endtask

  task automatic test_normal;
    test_reset;
    load_coins(2, 1, 2);
    do_dispense(175, 1'b0);
    checks++;
    if ({count_100, count_50, count_25} !== {4'd1, 4'd0, 4'd1} || dispensed !== 8'd175) begin
      failures++; $display("FAIL normal_final: counts=%h disp=%0d required 101 175", {count_100, count_50, count_25}, dispensed);
    end
  endtask

  task automatic test_non_multiple;
    load_coins(15, 15, 15);
    do_dispense(60, 1'b0);
  endtask

  task automatic test_insufficient;
    test_reset;
    load_coins(0, 0, 2);
    do_dispense(75, 1'b0);
    do_dispense(50, 1'b0);
    checks++;
    if (count_25 !== 4'd0 || dispensed !== 8'd50) begin
      failures++; $display("FAIL insufficient_final: count_25=%0d disp=%0d required 0 50", count_25, dispensed);
    end
  endtask

  task automatic test_load_boundaries;
    test_reset;
    load_coins(0, 0, 1);
    do_dispense(25, 1'b1);
    checks++;
    if (count_25 !== 4'd1) begin
      failures++; $display("FAIL load_and_sense: count_25=%0d required 1", count_25);
    end
    load_coins(0, 16, 0);
    checks++;
    if (count_50 !== 4'd15) begin
      failures++; $display("FAIL load_saturate: count_50=%0d required 15", count_50);
    end
  endtask

  task automatic test_zero_and_abort;
    do_dispense(0, 1'b0);
    load_coins(0, 0, 1);
    req = 1'b1; amount = 8'd25;
    tick;
    req = 1'b0;
    tick;
    checks++;
    if ({eject_100, eject_50, eject_25} !== 3'b001) begin
      failures++; $display("FAIL abort_eject: ej=%b required 001", {eject_100, eject_50, eject_25});
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    m25 = 0; m50 = 0; m100 = 0;
    checks++;
    if ({eject_100, eject_50, eject_25, busy, done, fail, jam} !== 7'd0 ||
        {count_100, count_50, count_25} !== 12'd0 || dispensed !== 8'd0) begin
      failures++; $display("FAIL abort_reset: ej=%b bdfj=%b counts=%h disp=%0d required all zero",
        {eject_100, eject_50, eject_25}, {busy, done, fail, jam}, {count_100, count_50, count_25}, dispensed);
    end
    // Idle after abort: a fresh zero request still completes.
    do_dispense(0, 1'b0);
  endtask

  task automatic test_random;
    int amt;
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 6)); k++) begin
        load_mix(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 3) == 0) amt = int'($urandom_range(0, 255));
      else amt = 25 * int'($urandom_range(0, 10));
      do_dispense(amt, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_jam;
    int k;
    load_coins(1, 0, 0);
    req = 1'b1; amount = 8'd100;
    tick;
    req = 1'b0;
    tick;
    checks++;
    if ({eject_100, eject_50, eject_25} !== 3'b100) begin
      failures++; $display("FAIL jam_first_eject: ej=%b required 100", {eject_100, eject_50, eject_25});
    end
    k = 0;
    while (jam !== 1'b1 && k < P + T + 20) begin
      tick;
      k++;
    end
    checks++;
    if (k != P + T) begin
      failures++; $display("FAIL jam_latency: cycles=%0d required %0d", k, P + T);
    end
    checks++;
    if ({eject_100, eject_50, eject_25} !== 3'b000 || busy !== 1'b1 || jam !== 1'b1) begin
      failures++; $display("FAIL jam_state: ej=%b busy=%b jam=%b required 000 1 1", {eject_100, eject_50, eject_25}, busy, jam);
    end
    req = 1'b1; amount = 8'd0;
    coin_sensed = 1'b1;
    tick;
    req = 1'b0; coin_sensed = 1'b0;
    tick;
    checks++;
    if (done !== 1'b0 || jam !== 1'b1 || busy !== 1'b1 || count_100 !== 4'(m100)) begin
      failures++; $display("FAIL jam_ignores_req: done=%b jam=%b busy=%b c100=%0d required 0 1 1 %0d", done, jam, busy, count_100, m100);
    end
    load_coins(0, 0, 1);
    checks++;
    if ({count_100, count_50, count_25} !== model_counts() || jam !== 1'b1) begin
      failures++; $display("FAIL jam_load: counts=%h jam=%b required %h 1", {count_100, count_50, count_25}, jam, model_counts());
    end
    test_reset;
  endtask

  initial begin
    test_reset;
    test_normal;
    test_non_multiple;
    test_insufficient;
    test_load_boundaries;
    test_zero_and_abort;
    test_random;
    test_jam;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-change dispense controller for the vending machine. It owns the inventory of the three coin tubes (25, 50 and 100). On request it converts a change value into a per-denomination coin plan and sequences the ejector solenoids one coin at a time, confirming each coin with the drop sensor. It sits between the sale FSM (which issues `req`/`amount` in its change state) and the coin-mechanism I/O, replacing the one-shot change arithmetic with a real dispense sequencer.

## Interface

Parameters:
- `PULSE_CYCLES`, 4 — cycles each `eject_*` is held high per coin (≥1).
- `GAP_CYCLES`, 2 — idle cycles between coins (≥1).
- `TIMEOUT_CYCLES`, 64 — cycles to wait for `coin_sensed` after a pulse ends before declaring a jam.
- `TUBE_MAX`, 15 — tube capacity; inventory counters saturate here.

Ports:
- `clock` in 1 — single clock; all logic is on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `req` in 1 — start dispense; sampled only in IDLE.
- `amount` in 8 — change value in cents; sampled with `req`.
- `load_25`, `load_50`, `load_100` in 1 each — one coin of that value added to its tube this cycle.
- `coin_sensed` in 1 — single-cycle pulse from the drop sensor.
- `eject_25`, `eject_50`, `eject_100` out 1 each — solenoid drives.
- `busy` out 1 — high in every state except IDLE.
- `done` out 1 — one-cycle pulse, successful completion.
- `fail` out 1 — one-cycle pulse, change cannot be made; nothing ejected.
- `jam` out 1 — sticky jam indication.
- `count_25`, `count_50`, `count_100` out 4 each — tube inventory.
- `dispensed` out 8 — value ejected so far in the current or last request.

## Operation

- **Reset:** all outputs are 0, counts are 0, `dispensed` is 0, and the state is IDLE. Reset mid-sequence aborts immediately; the next cycle shows these reset values.
- **States:** IDLE, PLAN, EJECT, WAIT, GAP, DONE, FAIL, JAM.
- **IDLE:**
  - `req`=1 latches `amount`, clears `dispensed` and goes to PLAN.
  - `req` in any other state is ignored.
- **PLAN (one cycle), greedy with availability:**
  - n100 = min(amount/100, count_100); r = amount − 100·n100.
  - n50 = min(r/50, count_50); r −= 50·n50.
  - n25 = min(r/25, count_25); r −= 25·n25.
  - The remaining-coin counters are 4 bits wide (n25 ≤ 10).
  - If r≠0 (this covers amounts that are not multiples of 25 and insufficient inventory), go to FAIL.
  - Else if all n are 0 (amount 0), go to DONE.
  - Else go to EJECT.
- **Coin order:** all 100s, then 50s, then 25s. The current denomination is the highest one with remaining n>0.
- **EJECT:** the matching `eject_*` is high for exactly `PULSE_CYCLES` cycles, then the state goes to WAIT. Exactly one `eject_*` is ever high at a time.
- **WAIT:** `coin_sensed` is awaited.
  - If `coin_sensed` arrives during EJECT, it is remembered and WAIT is left on its first cycle.
  - On sense, the active count is decremented, `dispensed` increases by the coin value and the remaining n is decremented.
  - Next state is GAP if coins remain, else DONE.
- **GAP:** lasts `GAP_CYCLES` cycles, then returns to EJECT.
- **Timeout:** if no sense arrives within `TIMEOUT_CYCLES` WAIT cycles, go to JAM.
- **JAM:**
  - `jam`=1, `busy`=1 and all `eject_*`=0.
  - Only `reset` leaves this state.
  - Loads are still counted.
- **DONE / FAIL:** each lasts one cycle with its pulse asserted, then returns to IDLE.
- **Stray sense:** `coin_sensed` in IDLE, PLAN, GAP, DONE, FAIL or JAM is ignored.
- **Loads:**
  - Accepted in every state. Each load increments its count, saturating at `TUBE_MAX`; a load at `TUBE_MAX` is dropped.
  - A load and a sensed decrement on the same tube in the same cycle leave the count unchanged.
  - The plan is fixed in PLAN; later loads do not alter it.

## Timing

- **`req` at edge N:**
  - PLAN in cycle N+1.
  - `done`/`fail` in cycle N+2 for zero-coin and fail cases.
  - Otherwise the first `eject_*` rises in cycle N+2.
- **Per-coin period** with sense at the first WAIT cycle: `PULSE_CYCLES` + 1 + `GAP_CYCLES`. The last coin replaces GAP with a single DONE cycle.
- **Jam latency:** `jam` rises `PULSE_CYCLES` + `TIMEOUT_CYCLES` cycles after that coin's `eject_*` rises.
- **Registered outputs:** all outputs are registered and change only on the clock edge.
- **`busy`:** falls in the cycle after DONE or FAIL. `req` may be reasserted in that same IDLE cycle.

## Test plan

1. **Normal dispense.** Reset. Load 2×100, 1×50, 2×25, then `req` with amount=175 and sense each coin at its first WAIT cycle. Required: ejects in the order 100, 50, 25, each `PULSE_CYCLES` long; `done` pulses once; counts end at 1/0/1 (100/50/25); `dispensed`=175.
2. **Non-multiple of 25.** Amount=60 with full tubes. Required: `fail` at N+2; no `eject_*` asserted; counts unchanged; `busy` low at N+3.
3. **Insufficient inventory.** Counts 0/0/2 (100/50/25), amount=75. Required: `fail` at N+2, nothing ejected. Then amount=50 succeeds with two 25s and count_25 ends at 0.
4. **Jam.** Never assert `coin_sensed`. Required: `jam` rises exactly `PULSE_CYCLES`+`TIMEOUT_CYCLES` cycles after the first eject rises; all ejects low; `busy` stays high; a later `req` is ignored; `reset` restores all reset values.
5. **Load boundaries.** Pulse `load_25` in the same cycle that a 25 is sensed: count_25 is unchanged. Issue 16 loads of `load_50` from 0: count_50 ends at 15.
6. **Zero amount and abort.** Amount=0: `done` at N+2 with no ejects. Assert `reset` during an EJECT cycle: the next cycle has all `eject_*`=0, counts=0 and state IDLE.
